// File: rtl/wb_pkg.sv
// Shared types for the writeback / register-file slice.
//   reg_code_t      4-bit architectural register code
//   REG_RAX/RDX/RSP well-known register codes
//   wb_state_t      writeback control state (RUN, DRAIN, HALTED)
//   wb_stage_ctl_t  destination codes and enables of the staged beat
package wb_pkg;

  localparam int REG_CODE_W = 4;

  typedef logic [REG_CODE_W-1:0] reg_code_t;

  localparam reg_code_t REG_RAX = 4'd0;
  localparam reg_code_t REG_RDX = 4'd2;
  localparam reg_code_t REG_RSP = 4'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

  typedef struct packed {
    reg_code_t dest;
    logic      dest_vld;
    reg_code_t spec;
    logic      spec_vld;
  } wb_stage_ctl_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst          clock, asynchronous active-high reset
//   set_en/set_code   mark a register busy at the edge
//   clr_a_*, clr_b_*  release registers at the edge (commit destinations)
//   busy              bit i = register i in flight
// A set and a clear of the same bit in one edge leaves the bit set.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  reg_code_t           set_code,
  input  logic                clr_a_en,
  input  reg_code_t           clr_a_code,
  input  logic                clr_b_en,
  input  reg_code_t           clr_b_code,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((clr_a_en && (clr_a_code == reg_code_t'(i))) ||
          (clr_b_en && (clr_b_code == reg_code_t'(i)))) begin
        busy_d[i] = 1'b0;
      end
      // Applied after the clears so a same-edge reserve survives.
      if (set_en && (set_code == reg_code_t'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file.
// Accepts one executed beat per cycle from execute, holds it for one cycle
// in a single-entry stage, then commits primary/special results to a
// NUM_REGS x DATA_W register file. Two combinational read ports bypass from
// the staged beat. A busy scoreboard tracks in-flight destinations, and a
// return-class beat drains the stage and halts the block until reset.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   wbValidIn / wbReadyOut     execute-result handshake
//   currentRipIn               RIP of the beat
//   aluResultIn                primary result
//   aluResultSpecialIn         special result (MUL high half)
//   destRegIn/destRegValidIn   primary destination and enable
//   destRegSpecialIn/...ValidIn special destination and enable
//   haltIn                     beat is RET/RETF/IRET
//   readReg1In/readReg2In      read addresses
//   readVal1Out/readVal2Out    read data (combinational)
//   reserveValidIn/reserveRegIn decode marks a destination busy
//   busyOut                    scoreboard vector
//   lastRipOut                 RIP of the last committed beat
//   haltedOut                  drained after halt
//   retiredCountOut            commit counter (only with WB_RETIRE_COUNT_EN)
//
// Build option: define WB_RETIRE_COUNT_EN to add the 64-bit retired-beat
// counter and its output port.
module writeback_regfile
  import wb_pkg::*;
#(
  parameter int                NUM_REGS = 16,
  parameter int                DATA_W   = 64,
  parameter int                RIP_W    = 32,
  parameter logic [DATA_W-1:0] INIT_RSP = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wbValidIn,
  output logic                wbReadyOut,
  input  logic [RIP_W-1:0]    currentRipIn,
  input  logic [DATA_W-1:0]   aluResultIn,
  input  logic [DATA_W-1:0]   aluResultSpecialIn,
  input  logic [3:0]          destRegIn,
  input  logic                destRegValidIn,
  input  logic [3:0]          destRegSpecialIn,
  input  logic                destRegSpecialValidIn,
  input  logic                haltIn,
  input  logic [3:0]          readReg1In,
  input  logic [3:0]          readReg2In,
  output logic [DATA_W-1:0]   readVal1Out,
  output logic [DATA_W-1:0]   readVal2Out,
  input  logic                reserveValidIn,
  input  logic [3:0]          reserveRegIn,
  output logic [NUM_REGS-1:0] busyOut,
  output logic [RIP_W-1:0]    lastRipOut,
`ifdef WB_RETIRE_COUNT_EN
  output logic [63:0]         retiredCountOut,
`endif
  output logic                haltedOut
);

  // Codes at or above NUM_REGS are neither written nor bypassed.
  function automatic logic code_in_range(input reg_code_t code);
    return ({1'b0, code} < 5'(NUM_REGS));
  endfunction

  wb_state_t           state_q, state_d;
  logic                stage_vld_q, stage_vld_d;
  wb_stage_ctl_t       stage_ctl_q, stage_ctl_d;
  logic [DATA_W-1:0]   stage_alu_q, stage_alu_d;
  logic [DATA_W-1:0]   stage_spec_q, stage_spec_d;
  logic [RIP_W-1:0]    stage_rip_q, stage_rip_d;
  logic [RIP_W-1:0]    last_rip_q, last_rip_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic accept;
  logic commit;
  logic wr_prim;
  logic wr_spec;

  assign wbReadyOut = (state_q == RUN);
  assign haltedOut  = (state_q == HALTED);
  assign accept     = wbValidIn && wbReadyOut;
  assign commit     = stage_vld_q;
  assign wr_prim    = commit && stage_ctl_q.dest_vld && code_in_range(stage_ctl_q.dest);
  assign wr_spec    = commit && stage_ctl_q.spec_vld && code_in_range(stage_ctl_q.spec);
  assign lastRipOut = last_rip_q;

  // ---- accept -> stage ----
  always_comb begin
    stage_vld_d  = accept;
    stage_ctl_d  = stage_ctl_q;
    stage_alu_d  = stage_alu_q;
    stage_spec_d = stage_spec_q;
    stage_rip_d  = stage_rip_q;
    if (accept) begin
      stage_ctl_d.dest     = destRegIn;
      stage_ctl_d.dest_vld = destRegValidIn;
      stage_ctl_d.spec     = destRegSpecialIn;
      stage_ctl_d.spec_vld = destRegSpecialValidIn;
      stage_alu_d          = aluResultIn;
      stage_spec_d         = aluResultSpecialIn;
      stage_rip_d          = currentRipIn;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && haltIn) state_d = DRAIN;
      DRAIN:   if (commit) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stage_vld_q <= 1'b0;
      stage_ctl_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_vld_q <= stage_vld_d;
      stage_ctl_q <= stage_ctl_d;
    end
  end

  always_ff @(posedge clk) begin
    stage_alu_q  <= stage_alu_d;
    stage_spec_q <= stage_spec_d;
    stage_rip_q  <= stage_rip_d;
  end

  // ---- stage -> register file commit ----
  always_comb begin
    regs_d     = regs_q;
    last_rip_d = last_rip_q;
    if (commit) begin
      last_rip_d = stage_rip_q;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      // Primary written last so it wins when both codes match.
      if (wr_spec && (stage_ctl_q.spec == reg_code_t'(i))) begin
        regs_d[i] = stage_spec_q;
      end
      if (wr_prim && (stage_ctl_q.dest == reg_code_t'(i))) begin
        regs_d[i] = stage_alu_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_rip_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (reg_code_t'(i) == REG_RSP) ? INIT_RSP : '0;
      end
    end else begin
      last_rip_q <= last_rip_d;
      regs_q     <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input reg_code_t code);
    logic [DATA_W-1:0] val;
    val = '0;
    if (code_in_range(code)) begin
      if (stage_vld_q && stage_ctl_q.dest_vld && (stage_ctl_q.dest == code)) begin
        val = stage_alu_q;
      end else if (stage_vld_q && stage_ctl_q.spec_vld && (stage_ctl_q.spec == code)) begin
        val = stage_spec_q;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (code == reg_code_t'(i)) val = regs_q[i];
        end
      end
    end
    return val;
  endfunction

  always_comb begin
    readVal1Out = read_port(readReg1In);
    readVal2Out = read_port(readReg2In);
  end

  wb_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (reset),
    .set_en    (reserveValidIn && (state_q != HALTED)),
    .set_code  (reserveRegIn),
    .clr_a_en  (wr_prim),
    .clr_a_code(stage_ctl_q.dest),
    .clr_b_en  (wr_spec),
    .clr_b_code(stage_ctl_q.spec),
    .busy      (busyOut)
  );

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (commit) retired_cnt_d = retired_cnt_q + 64'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign retiredCountOut = retired_cnt_q;
`endif

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the execute-result interface. Accepts one executed instruction per beat: ALU result, special result, destination codes and RIP.
- Buffers the beat in a one-entry writeback stage, then commits it to a 16 x 64-bit architectural register file.
- Serves two operand-read ports with bypass from the staged beat.
- Keeps a per-register busy scoreboard so decode can stall on in-flight destinations.
- Drains and halts on a return-class instruction.

Parameters:
- NUM_REGS, 16, architectural GPR count; codes 0..NUM_REGS-1.
- DATA_W, 64, register and result width.
- RIP_W, 32, instruction pointer width.
- INIT_RSP, 64'h0, reset value of register 4 (RSP).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- wbValidIn  in  1  execute presents a beat
- wbReadyOut  out  1  stage can accept a beat
- currentRipIn  in  RIP_W  RIP of the beat
- aluResultIn  in  DATA_W  primary result
- aluResultSpecialIn  in  DATA_W  special result (MUL high half)
- destRegIn  in  4  primary destination code
- destRegValidIn  in  1  primary write enable
- destRegSpecialIn  in  4  special destination code
- destRegSpecialValidIn  in  1  special write enable
- haltIn  in  1  beat is RET/RETF/IRET; qualified by wbValidIn
- readReg1In, readReg2In  in  4  read addresses
- readVal1Out, readVal2Out  out  DATA_W  read data (combinational)
- reserveValidIn  in  1  decode reserves a destination
- reserveRegIn  in  4  register to mark busy
- busyOut  out  NUM_REGS  scoreboard, bit i = reg i in flight
- lastRipOut  out  RIP_W  RIP of the last committed beat
- haltedOut  out  1  pipeline drained after halt

Behaviour:
- Reset (async, any time, including mid-drain):
  - all registers 0 except reg 4 = INIT_RSP
  - stage empty, busyOut = 0, lastRipOut = 0, haltedOut = 0, state RUN
  - wbReadyOut = 1 in the first cycle after reset deasserts
- States: RUN, DRAIN, HALTED.
- Handshake:
  - A beat is accepted on a rising edge with wbValidIn && wbReadyOut.
  - wbReadyOut = 1 only in RUN.
  - Source holds all fields stable until accepted.
- Latency:
  - Beat accepted at edge N is held in the stage during cycle N..N+1.
  - It commits to the register file at edge N+1.
  - The stage drains every cycle, so back-to-back beats sustain 1 beat/cycle.
- Commit writes:
  - Primary value written if destRegValidIn was 1; special value written if destRegSpecialValidIn was 1; both in the same edge.
  - If both codes are equal and both valid, the primary value wins.
  - Neither valid: no register change; lastRipOut still updates.
- Reads:
  - readValXOut = staged primary value if the stage is valid, primary-valid and the code matches.
  - Else the staged special value if special-valid and matching.
  - Else the register file.
- Scoreboard:
  - At commit, bits for the valid primary/special codes clear.
  - reserveValidIn sets bit reserveRegIn at the edge.
  - Set and clear of the same bit in one edge: set wins.
  - Reserve is ignored in HALTED.
- Halt sequence:
  - RUN: accepted beat with haltIn=1 -> DRAIN (its register writes still commit).
  - DRAIN: at the edge where the stage commits -> HALTED.
  - HALTED: haltedOut=1, wbReadyOut=0, register file frozen, reads still served. Left only by reset.
- Arithmetic: none. Values stored verbatim; codes >= NUM_REGS are ignored for writes and read as 0.

Optional Feature:
- WB_RETIRE_COUNT_EN defined:
  - adds output retiredCountOut (64 bits), reset 0
  - +1 at every commit, including the halt beat
  - wraps modulo 2^64
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - reg-code typedef (4 bits) and constants REG_RAX=0, REG_RDX=2, REG_RSP=4
  - state enum {RUN, DRAIN, HALTED}
  - a struct grouping the staged beat fields
- One sub-module, wb_scoreboard: busy vector with set-priority update.

Test Plan:
- Reset with INIT_RSP=64'h7FF0 -> reg4 reads 64'h7FF0, all other regs 0, busyOut=0, wbReadyOut=1, haltedOut=0.
- Beat: dest=0 valid, aluResult=64'h1234, RIP 32'h100 -> readReg1In=0 returns 64'h1234 in the cycle after accept (bypass) and after commit; lastRipOut=32'h100.
- MUL beat: dest=0 value 64'hA, special=2 value 64'hB; then a beat with both codes=3, values 5 and 6 -> reg0=A, reg2=B, reg3=5.
- Reserve reg 5, then commit to reg 5 in the same edge as a new reserve of reg 5 -> busyOut[5] stays 1; commit with no reserve -> 0.
- Back-to-back beats to regs 1, 2, 3 over 3 cycles -> wbReadyOut held 1, all three values committed in order.
- Halt beat writing reg 6 = 64'h9 -> next cycle wbReadyOut=0; haltedOut=1 after commit; reg6=9; reset mid-DRAIN returns to RUN with registers cleared.
